// File: rtl/cpu_pkg.sv
// Shared CPU types: PC state encoding and datapath widths.
// Imported by the PC unit and the next-PC mux.
package cpu_pkg;

  localparam int unsigned WORD = 32;
  localparam logic [WORD-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    FAULT = 2'd3
  } pc_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority select and target adders.
// Reused by the pipelined core.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [WORD-1:0] pc_plus4_i,
  input  logic [WORD-1:0] branch_offset_i,
  input  logic            take_branch_i,
  input  logic            jump_i,
  input  logic [25:0]     jump_index_i,
  input  logic            jump_reg_i,
  input  logic [WORD-1:0] jump_reg_addr_i,
  output logic [WORD-1:0] target_o,
  output logic            redirect_o
);

  logic [WORD-1:0] br_tgt;
  logic [WORD-1:0] j_tgt;

  assign br_tgt = pc_plus4_i + branch_offset_i;
  assign j_tgt  = {pc_plus4_i[31:28], jump_index_i, 2'b00};

  assign redirect_o = jump_reg_i | jump_i | take_branch_i;

  always_comb begin
    target_o = pc_plus4_i;
    priority case (1'b1)
      jump_reg_i:    target_o = jump_reg_addr_i;
      jump_i:        target_o = j_tgt;
      take_branch_i: target_o = br_tgt;
      default:       target_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register, redirect buffer and fetch handshake.
// Target selection lives in next_pc_mux.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] branch_offset,
  input  logic        take_branch,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        misaligned
);

  pc_state_t       st_q;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] pend_pc_q;
  logic            fv_q;
  logic            mis_q;

  logic [WORD-1:0] tgt;
  logic            redirect;
  logic            adv;
  logic            jr_fault;

  assign pc_plus4    = pc_q + PC_INCR;
  assign pc          = pc_q;
  assign fetch_valid = fv_q;
  assign misaligned  = mis_q;

  assign adv      = fv_q & imem_ready & ~stall;
  assign jr_fault = jump_reg & (|jump_reg_addr[1:0]);

  next_pc_mux u_mux (
    .pc_plus4_i      (pc_plus4),
    .branch_offset_i (branch_offset),
    .take_branch_i   (take_branch),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .jump_reg_i      (jump_reg),
    .jump_reg_addr_i (jump_reg_addr),
    .target_o        (tgt),
    .redirect_o      (redirect)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      fv_q      <= 1'b0;
      mis_q     <= 1'b0;
    end else if (st_q != FAULT) begin
      if (jr_fault) begin
        st_q  <= FAULT;
        fv_q  <= 1'b0;
        mis_q <= 1'b1;
      end else begin
        unique case (st_q)
          BOOT: begin
            st_q <= RUN;
            fv_q <= 1'b1;
          end
          RUN: begin
            if (adv) begin
              pc_q <= tgt;
            end else if (redirect) begin
              pend_pc_q <= tgt;
              st_q      <= PEND;
            end
          end
          PEND: begin
            // a redirect arriving in the same cycle supersedes the buffer
            if (adv) begin
              pc_q <= redirect ? tgt : pend_pc_q;
              st_q <= RUN;
            end else if (redirect) begin
              pend_pc_q <= tgt;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed literal checks plus
// random stimulus against a behavioural model.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] branch_offset;
  logic        take_branch;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_addr;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .branch_offset (branch_offset),
    .take_branch   (take_branch),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jump_reg_addr (jump_reg_addr),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  // behavioural model
  bit          m_boot, m_fault, m_pend;
  logic [31:0] m_pc, m_pendpc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sel_target(input logic [31:0] cur);
    logic [31:0] p4;
    p4 = cur + 32'd4;
    if (jump_reg)         return jump_reg_addr;
    else if (jump)        return {p4[31:28], jump_index, 2'b00};
    else if (take_branch) return p4 + branch_offset;
    return p4;
  endfunction

  always @(posedge clk) begin
    bit redir, adv;
    logic [31:0] t;
    redir = jump_reg | jump | take_branch;
    adv   = !m_boot && !m_fault && imem_ready && !stall;
    t     = sel_target(m_pc);
    if (reset) begin
      m_boot = 1; m_fault = 0; m_pend = 0;
      m_pc = 32'h0; m_pendpc = 32'h0;
    end else if (m_fault) begin
    end else if (jump_reg && jump_reg_addr[1:0] != 2'b00) begin
      m_fault = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (adv) begin
      m_pc   = redir ? t : (m_pend ? m_pendpc : m_pc + 32'd4);
      m_pend = 0;
    end else if (redir) begin
      m_pend   = 1;
      m_pendpc = t;
    end
    #1;
    chk("model_pc", pc, m_pc);
    chk("model_pc4", pc_plus4, m_pc + 32'd4);
    chk("model_fv", {31'd0, fetch_valid}, {31'd0, !m_boot && !m_fault});
    chk("model_mis", {31'd0, misaligned}, {31'd0, m_fault});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    take_branch = 0; jump = 0; jump_reg = 0;
    branch_offset = 0; jump_index = 0; jump_reg_addr = 0;
    stall = 0;
  endtask

  task automatic set_pc(input logic [31:0] a);
    jump_reg = 1; jump_reg_addr = a;
    tick();
    jump_reg = 0;
  endtask

  initial begin
    reset = 1; imem_ready = 1;
    idle();
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    reset = 0;
    tick(); chk("seq0", pc, 32'h0);
    chk("fv_run", {31'd0, fetch_valid}, 32'd1);
    tick(); chk("seq4", pc, 32'h4);
    tick(); chk("seq8", pc, 32'h8);
    tick(); chk("seq12", pc, 32'hC);

    set_pc(32'h100);
    chk("jr100", pc, 32'h100);
    take_branch = 1; branch_offset = 32'hFFFF_FFF0;
    tick(); idle();
    chk("br_back", pc, 32'hF4);

    set_pc(32'hFFFF_FFFC);
    tick(); chk("wrap", pc, 32'h0);

    set_pc(32'h4000_0010);
    jump = 1; jump_index = 26'h000_0040;
    tick(); idle();
    chk("jump", pc, 32'h4000_0100);

    set_pc(32'h20);
    imem_ready = 0; jump_reg = 1; jump_reg_addr = 32'h800;
    tick(); idle();
    chk("pend_hold", pc, 32'h20);
    tick(); tick();
    chk("pend_hold2", pc, 32'h20);
    chk("pend_fv", {31'd0, fetch_valid}, 32'd1);
    imem_ready = 1;
    tick(); chk("pend_rel", pc, 32'h800);

    imem_ready = 0; jump_reg = 1; jump_reg_addr = 32'h40;
    tick(); idle();
    imem_ready = 1; stall = 1; take_branch = 1; branch_offset = 32'd8;
    tick(); idle();
    chk("ovr_hold", pc, 32'h800);
    tick(); chk("ovr", pc, 32'h80C);

    jump = 1; take_branch = 1; jump_index = 26'h10; branch_offset = 32'h100;
    tick(); idle();
    chk("j_over_br", pc, 32'h40);

    jump_reg = 1; jump_reg_addr = 32'h802;
    tick(); idle();
    chk("flt_mis", {31'd0, misaligned}, 32'd1);
    chk("flt_fv", {31'd0, fetch_valid}, 32'd0);
    chk("flt_pc", pc, 32'h40);
    jump = 1; jump_index = 26'h3FF;
    tick(); tick(); idle();
    chk("flt_frozen", pc, 32'h40);
    reset = 1;
    tick();
    chk("flt_rst_pc", pc, 32'h0);
    chk("flt_rst_mis", {31'd0, misaligned}, 32'd0);
    reset = 0;

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      reset         = ($urandom_range(0, 199) == 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      take_branch   = ($urandom_range(0, 5) == 0);
      branch_offset = {$urandom_range(0, 32'hFFFF) , 16'h0} >> 14;
      jump          = ($urandom_range(0, 7) == 0);
      jump_index    = 26'($urandom);
      jump_reg      = ($urandom_range(0, 7) == 0);
      jump_reg_addr = {$urandom} & ((r < 3) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      tick();
    end
    idle(); reset = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter register and next-PC selection for the single-cycle datapath. It sits directly downstream of the two-place left shifter. It consumes the shifted, sign-extended branch offset and adds it to PC+4 to form branch targets. It also forms jump and jump-register targets, buffers redirects that arrive while instruction fetch is blocked, and presents the fetch address to instruction memory with a valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address loaded on reset.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `branch_offset`  in  32: sign-extended immediate already shifted left two places.
- `take_branch`  in  1: branch condition true this cycle.
- `jump`  in  1: J/JAL this cycle.
- `jump_index`  in  26: instr[25:0].
- `jump_reg`  in  1: JR/JALR this cycle.
- `jump_reg_addr`  in  32: register operand for JR.
- `stall`  in  1: hazard hold; blocks PC advance.
- `imem_ready`  in  1: instruction memory accepts the current fetch.
- `pc`  out  32: current fetch address, registered.
- `pc_plus4`  out  32: `pc` + 4, combinational.
- `fetch_valid`  out  1: `pc` is a valid fetch request.
- `misaligned`  out  1: sticky JR alignment fault.

## Operation
- States:
  - `BOOT`: entered on reset for one cycle; `fetch_valid` = 0. Always moves to `RUN`.
  - `RUN`: normal operation.
  - `PEND`: a redirect target is buffered.
  - `FAULT`: terminal until reset.
- Advance condition: `adv` = `fetch_valid` & `imem_ready` & !`stall`.
- Target selection (priority, highest first):
  - `jump_reg` → `jump_reg_addr`
  - `jump` → {`pc_plus4`[31:28], `jump_index`, 2'b00}
  - `take_branch` → `pc_plus4` + `branch_offset`
  - none → `pc_plus4`
- All additions are modulo 2^32 and wrap silently: 32'hFFFF_FFFC + 4 = 0.
- `RUN` behaviour:
  - If `adv`, `pc` ← selected target.
  - If a redirect is asserted and `adv` = 0, latch the target into `pend_pc` and go to `PEND`. `pc` holds.
- `PEND` behaviour:
  - If a new redirect is asserted, it overwrites `pend_pc`; the latest one wins.
  - On `adv`, `pc` ← `pend_pc` (or the new redirect target if one is asserted in the same cycle), then go to `RUN`.
- Alignment fault:
  - `jump_reg` with `jump_reg_addr`[1:0] ≠ 0 → `FAULT`, in any state, regardless of `adv`.
  - In `FAULT`: `pc` holds, `misaligned` = 1, `fetch_valid` = 0, and all further inputs are ignored.
- Branch and jump targets are aligned by construction and are never checked.

## Timing
- Reset values: `pc` = `RESET_PC`, `fetch_valid` = 0, `misaligned` = 0, `pend_pc` = 0, state = `BOOT`.
- Reset overrides everything in the same edge, including `FAULT` and `PEND`; a buffered redirect is discarded.
- `fetch_valid` = 1 in `RUN` and `PEND`, beginning the cycle after `BOOT`.
- Latency: the target selected in cycle N appears on `pc` in cycle N+1 when `adv` is true in cycle N.
- `fetch_valid` stays high and `pc` stays stable while `imem_ready` = 0 or `stall` = 1.
- Redirect inputs are one-cycle pulses from decode. An unbuffered redirect must never be lost.
- `stall` and `imem_ready` = 0 are equivalent for PC hold purposes.
- `pc_plus4` is combinational from `pc` and carries no extra register stage.

## Structure
- Shared package `cpu_pkg`:
  - `pc_state_t` enum (`BOOT`, `RUN`, `PEND`, `FAULT`)
  - `PC_INCR` = 32'd4
  - `WORD` width constant = 32
- Sub-module `next_pc_mux`: combinational priority select and adders, giving target plus a `redirect` flag. It is reused by the pipelined core later.
- The top level holds only the FSM and the `pc`/`pend_pc` registers.

## Test plan
- Reset, then `imem_ready` = 1 for 4 cycles → `fetch_valid` low in the `BOOT` cycle, then `pc` = 0, 4, 8, 12.
- Branch backward: `pc` = 32'h100, `take_branch` = 1, `branch_offset` = 32'hFFFF_FFF0 → next `pc` = 32'hF4.
- Wrap-around and jump:
  - `pc` = 32'hFFFF_FFFC, no redirect → `pc` = 0.
  - `pc` = 32'h4000_0010, `jump` = 1, `jump_index` = 26'h000_0040 → `pc` = 32'h4000_0100.
- Buffered redirect:
  - `imem_ready` = 0 while `pc` = 32'h20; pulse `jump_reg` with `jump_reg_addr` = 32'h800 → `PEND`, `pc` holds at 32'h20.
  - Raise `imem_ready` two cycles later → `pc` = 32'h800.
- Overwrite and simultaneous events:
  - In `PEND`, pulse `take_branch` with offset 8 while `stall` = 1 → `pend_pc` = `pc_plus4` + 8.
  - Assert `jump` and `take_branch` together → the jump target is selected.
- Fault: `jump_reg_addr` = 32'h802 → `misaligned` = 1, `fetch_valid` = 0, `pc` frozen. Assert `reset` → `pc` = `RESET_PC`, `misaligned` = 0.
